// File: rtl/hk_sram_ro_reader_pkg.sv
// Shared types for the housekeeping SRAM read-only burst reader: FSM encoding and width defaults.
package hk_sram_ro_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } state_e;

endpackage

// File: rtl/hk_word_serializer.sv
// Presents a loaded 32-bit word as four bytes, LSB first; first byte valid the cycle after load.
// Byte, last flag and valid hold while out_ready_i is low; abort_i drops valid on the next edge.
module hk_word_serializer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        last_i,
    input  logic        abort_i,
    input  logic        out_ready_i,
    output logic        out_valid_o,
    output logic [7:0]  out_byte_o,
    output logic        out_last_o,
    output logic        done_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;
    logic        fire;

    assign fire = vld_q && out_ready_i;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = 2'd0;
            vld_d  = 1'b1;
            last_d = last_i;
        end else if (abort_i) begin
            vld_d = 1'b0;
            idx_d = 2'd0;
        end else if (fire) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign out_valid_o = vld_q;
    assign out_byte_o  = word_q[{idx_q, 3'b000} +: 8];
    // The last flag belongs to the word, so it is only shown on its final byte.
    assign out_last_o  = vld_q && last_q && (idx_q == 2'd3);
    assign done_o      = fire && (idx_q == 2'd3);

endmodule

// File: rtl/hk_sram_ro_reader.sv
// Burst reader: one select per word on the SRAM read-only port, bytes streamed out; first byte 3 cycles after accept.
// Output waits on out_ready with no read-ahead, so 2 idle cycles (SEL, WAIT) separate consecutive words.
module hk_sram_ro_reader
    import hk_sram_ro_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic              busy,
    output logic              sram_ro_clk,
    output logic              sram_ro_csb,
    output logic [ADDR_W-1:0] sram_ro_addr,
    input  logic [31:0]       sram_ro_data
);

    // One extra bit so a zero length can stand for the full 2^LEN_W words.
    localparam int CNT_W = LEN_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ser_load;
    logic              ser_last;
    logic              ser_done;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        ser_load = 1'b0;
        ser_last = (cnt_q == CNT_W'(1));
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    cnt_d   = (req_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, req_len};
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                state_d = abort ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    ser_load = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ser_done) begin
                    state_d = (cnt_q != '0) ? ST_SEL : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    hk_word_serializer u_ser (
        .clk_i       (core_clk),
        .rst_i       (core_rst),
        .load_i      (ser_load),
        .word_i      (sram_ro_data),
        .last_i      (ser_last),
        .abort_i     (abort),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_byte_o  (out_byte),
        .out_last_o  (out_last),
        .done_o      (ser_done)
    );

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign sram_ro_clk  = core_clk;
    assign sram_ro_csb  = (state_q != ST_SEL);
    assign sram_ro_addr = addr_q;

endmodule
